// File: rtl/sort_pkg.sv
// Shared definitions for the selection-sort datapath blocks.
//   DEF_SIZE_ADDR / DEF_SIZE_DATA : default sort-memory address and data widths
//   CNT_W / CNT_MAX               : width and ceiling of the swap counter
//   state_t                       : swap FSM state encoding
//   sat_inc()                     : saturating increment for the swap counter
package sort_pkg;

    localparam int DEF_SIZE_ADDR = 8;
    localparam int DEF_SIZE_DATA = 8;

    localparam int               CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_I   = 3'd1,
        RD_MIN = 3'd2,
        CAP    = 3'd3,
        WR_I   = 3'd4,
        WR_MIN = 3'd5,
        DONE   = 3'd6
    } state_t;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/swap_min.sv
// swap_min: exchanges the words at addr_i and addr_min of a single-port RAM
// with a registered read (data returns one cycle after the address).
//
// Ports
//   i_clk        clock, all state changes on the rising edge
//   i_rst_n      asynchronous active-low reset
//   i_start      request one swap, only honoured while idle
//   i_addr_i     outer-loop position i
//   i_addr_min   address of the current minimum
//   o_mem_addr   RAM address
//   o_mem_we     RAM write enable
//   o_mem_wdata  RAM write data
//   i_mem_rdata  RAM read data
//   o_busy       high whenever a swap is in progress
//   o_done       one-cycle pulse at the end of a swap
//   o_swap_cnt   saturating count of swaps that wrote memory
module swap_min
    import sort_pkg::*;
#(
    parameter int SIZE_ADDR = DEF_SIZE_ADDR,
    parameter int SIZE_DATA = DEF_SIZE_DATA
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [SIZE_ADDR-1:0] i_addr_i,
    input  logic [SIZE_ADDR-1:0] i_addr_min,
    output logic [SIZE_ADDR-1:0] o_mem_addr,
    output logic                 o_mem_we,
    output logic [SIZE_DATA-1:0] o_mem_wdata,
    input  logic [SIZE_DATA-1:0] i_mem_rdata,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [CNT_W-1:0]     o_swap_cnt
);

    state_t               state;
    state_t               state_nxt;
    logic [SIZE_ADDR-1:0] addr_i;
    logic [SIZE_ADDR-1:0] addr_min;
    logic [SIZE_DATA-1:0] data_i;
    logic [SIZE_DATA-1:0] data_min;
    logic [SIZE_DATA-1:0] wdata_hold;
    logic                 same_addr;

    assign same_addr = (i_addr_i == i_addr_min);

    // Next-state logic. Equal addresses skip straight to DONE: swapping a
    // word with itself needs no memory traffic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (i_start) begin
                    state_nxt = same_addr ? DONE : RD_I;
                end
            end
            RD_I:    state_nxt = RD_MIN;
            RD_MIN:  state_nxt = CAP;
            CAP:     state_nxt = WR_I;
            WR_I:    state_nxt = WR_MIN;
            WR_MIN:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Address, data and strobe registers. Each output is loaded on the edge
    // that enters the state it belongs to, so it is valid for that whole
    // state and otherwise keeps its previous value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_i     <= '0;
            addr_min   <= '0;
            data_i     <= '0;
            data_min   <= '0;
            wdata_hold <= '0;
            o_mem_addr <= '0;
            o_mem_we   <= 1'b0;
            o_swap_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_start) begin
                        // Addresses are frozen here; later input changes
                        // cannot disturb the swap in flight.
                        addr_i   <= i_addr_i;
                        addr_min <= i_addr_min;
                        if (!same_addr) begin
                            o_mem_addr <= i_addr_i;
                        end
                    end
                end
                RD_I: begin
                    o_mem_addr <= addr_min;
                end
                RD_MIN: begin
                    // Word at addr_i returns now (read issued in RD_I).
                    data_i <= i_mem_rdata;
                end
                CAP: begin
                    // Word at addr_min returns now (read issued in RD_MIN).
                    data_min   <= i_mem_rdata;
                    o_mem_addr <= addr_i;
                    o_mem_we   <= 1'b1;
                end
                WR_I: begin
                    o_mem_addr <= addr_min;
                end
                WR_MIN: begin
                    o_mem_we   <= 1'b0;
                    wdata_hold <= data_i;
                    o_swap_cnt <= sat_inc(o_swap_cnt);
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    // Write data follows the write state directly; outside the write window
    // the last value driven is held.
    always_comb begin
        o_mem_wdata = wdata_hold;
        unique case (state)
            WR_I:    o_mem_wdata = data_min;
            WR_MIN:  o_mem_wdata = data_i;
            default: o_mem_wdata = wdata_hold;
        endcase
    end

    assign o_busy = (state != IDLE);
    assign o_done = (state == DONE);

endmodule

// File: tb/tb_swap_min.sv
module tb_swap_min;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  addr_i = '0;
    logic [7:0]  addr_min = '0;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        done;
    logic [15:0] swap_cnt;

    logic [7:0]  ram [0:255];
    logic        load_en = 1'b0;
    logic [7:0]  load_addr = '0;
    logic [7:0]  load_data = '0;

    int total = 0;
    int bad = 0;

    logic [7:0] tr_addr [1:12];
    logic       tr_we   [1:12];
    logic [7:0] tr_wd   [1:12];
    int         done_cyc;
    int         we_cnt;
    int         extra;

    always #5 clk = ~clk;

    swap_min #(.SIZE_ADDR(8), .SIZE_DATA(8)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_addr_i   (addr_i),
        .i_addr_min (addr_min),
        .o_mem_addr (mem_addr),
        .o_mem_we   (mem_we),
        .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata),
        .o_busy     (busy),
        .o_done     (done),
        .o_swap_cnt (swap_cnt)
    );

    // Single-port RAM with registered read; load port is bench-only.
    always @(posedge clk) begin
        if (load_en) ram[load_addr] <= load_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        load_addr = a;
        load_data = d;
        load_en   = 1'b1;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    // Called at a falling edge; start is sampled on the next rising edge
    // (edge 0). Cycle c is observed at the falling edge after edge c-1.
    task automatic run_swap(input logic [7:0] ai, input logic [7:0] am, input bit pulse_again);
        done_cyc = 0;
        we_cnt   = 0;
        for (int k = 1; k <= 12; k++) begin
            tr_addr[k] = '0;
            tr_we[k]   = 1'b0;
            tr_wd[k]   = '0;
        end
        addr_i   = ai;
        addr_min = am;
        start    = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            tr_addr[c] = mem_addr;
            tr_we[c]   = mem_we;
            tr_wd[c]   = mem_wdata;
            if (mem_we) we_cnt++;
            if (c == 1) begin
                start    = 1'b0;
                addr_i   = ~ai;
                addr_min = am ^ 8'h5A;
            end
            if (pulse_again && c == 3) start = 1'b1;
            if (pulse_again && c == 4) start = 1'b0;
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy",  busy, 0);
        chk("rst_done",  done, 0);
        chk("rst_we",    mem_we, 0);
        chk("rst_addr",  mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_cnt",   swap_cnt, 0);

        load(8'd0, 8'hA0);
        load(8'd1, 8'hB1);
        load(8'd2, 8'hC2);
        load(8'd3, 8'h55);
        load(8'd4, 8'hE4);
        load(8'd5, 8'h5A);
        load(8'd6, 8'h66);
        load(8'd7, 8'h11);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic swap 3 <-> 7 with address inputs scrambled after acceptance
        run_swap(8'd3, 8'd7, 1'b0);
        chk("t1_done_cyc", done_cyc, 6);
        chk("t1_c1_addr",  tr_addr[1], 3);
        chk("t1_c1_we",    tr_we[1], 0);
        chk("t1_c2_addr",  tr_addr[2], 7);
        chk("t1_c3_we",    tr_we[3], 0);
        chk("t1_c4_addr",  tr_addr[4], 3);
        chk("t1_c4_we",    tr_we[4], 1);
        chk("t1_c4_wd",    tr_wd[4], 8'h11);
        chk("t1_c5_addr",  tr_addr[5], 7);
        chk("t1_c5_wd",    tr_wd[5], 8'h55);
        chk("t1_c6_we",    tr_we[6], 0);
        chk("t1_we_cnt",   we_cnt, 2);
        chk("t1_cnt",      swap_cnt, 1);
        @(negedge clk);
        chk("t1_busy_idle", busy, 0);
        chk("t1_ram3", ram[3], 8'h11);
        chk("t1_ram7", ram[7], 8'h55);

        // Equal addresses: immediate done, no writes, count unchanged
        run_swap(8'd5, 8'd5, 1'b0);
        chk("t2_done_cyc", done_cyc, 1);
        chk("t2_we_cnt",   we_cnt, 0);
        chk("t2_cnt",      swap_cnt, 1);
        @(negedge clk);
        chk("t2_ram5", ram[5], 8'h5A);

        // Start pulsed again mid-swap must be ignored
        run_swap(8'd3, 8'd7, 1'b1);
        chk("t3_done_cyc", done_cyc, 6);
        count_done(8, extra);
        chk("t3_extra_done", extra, 0);
        chk("t3_cnt",  swap_cnt, 2);
        chk("t3_ram3", ram[3], 8'h55);
        chk("t3_ram7", ram[7], 8'h11);

        // Back-to-back swaps, second start in the cycle after DONE
        run_swap(8'd0, 8'd2, 1'b0);
        chk("t4a_done_cyc", done_cyc, 6);
        @(negedge clk);
        run_swap(8'd1, 8'd4, 1'b0);
        chk("t4b_done_cyc", done_cyc, 6);
        chk("t4_cnt", swap_cnt, 4);
        @(negedge clk);
        chk("t4_ram0", ram[0], 8'hC2);
        chk("t4_ram2", ram[2], 8'hA0);
        chk("t4_ram1", ram[1], 8'hE4);
        chk("t4_ram4", ram[4], 8'hB1);

        // Reset asserted during WR_I
        addr_i   = 8'd1;
        addr_min = 8'd4;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_we_before", mem_we, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_we",   mem_we, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_cnt",  swap_cnt, 0);
        chk("t5_addr", mem_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_ram1", ram[1], 8'hE4);
        chk("t5_ram4", ram[4], 8'hB1);
        chk("t5_idle", busy, 0);

        // Saturation from 16'hFFFE
        force dut.o_swap_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.o_swap_cnt;
        chk("t6_preload", swap_cnt, 16'hFFFE);
        run_swap(8'd3, 8'd7, 1'b0);
        chk("t6_cnt1", swap_cnt, 16'hFFFF);
        @(negedge clk);
        run_swap(8'd0, 8'd2, 1'b0);
        chk("t6_cnt2", swap_cnt, 16'hFFFF);
        @(negedge clk);
        run_swap(8'd1, 8'd4, 1'b0);
        chk("t6_done_cyc", done_cyc, 6);
        chk("t6_cnt3", swap_cnt, 16'hFFFF);
        @(negedge clk);
        chk("t6_ram3", ram[3], 8'h11);
        chk("t6_ram7", ram[7], 8'h55);
        chk("t6_ram0", ram[0], 8'hA0);
        chk("t6_ram2", ram[2], 8'hC2);
        chk("t6_ram1", ram[1], 8'hB1);
        chk("t6_ram4", ram[4], 8'hE4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
